// File: rtl/anc_sat_combiner.sv
// anc_sat_combiner: multi-channel saturating error / anti-noise combiner, one channel per clock.
// Optional ANC_SAT_COUNT_EN compiles in the saturation event counter; otherwise SatCount is 0.
module anc_sat_combiner #(
  parameter int W        = 11,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  Clk_100M,
  input  logic                  Rst_n,
  input  logic [W*CHANNELS-1:0] FiltIn,
  input  logic [W*CHANNELS-1:0] MicIn,
  input  logic                  FiltComplete,
  output logic [W*CHANNELS-1:0] Err,
  output logic [W*CHANNELS-1:0] ANCAudioOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overrun,
  output logic [CNT_W-1:0]      SatCount
);
  localparam int N = W * CHANNELS;
  localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0] filt_q, filt_d, mic_q, mic_d, err_q, err_d, anc_q, anc_d;
  logic fc_q, done_q, done_d, ovr_q, ovr_d, start, run, last;
  logic signed [W-1:0] f, m, d_sat, a_sat;
  logic signed [W:0] d_w, a_w;
  // Widen by one bit so the only overflow case is a sign/MSB disagreement
  always_comb begin
    f = filt_q[idx_q*W +: W];
    m = mic_q[idx_q*W +: W];
    d_w = {m[W-1], m} - {f[W-1], f};
    a_w = {(W+1){1'b0}} - {f[W-1], f};
    d_sat = (d_w[W] != d_w[W-1]) ? {d_w[W], {(W-1){~d_w[W]}}} : d_w[W-1:0];
    a_sat = (a_w[W] != a_w[W-1]) ? {a_w[W], {(W-1){~a_w[W]}}} : a_w[W-1:0];
  end
  always_comb begin
    start = FiltComplete & ~fc_q;
    run = state_q == RUN;
    last = idx_q == LAST;
    state_d = state_q;
    idx_d = idx_q;
    filt_d = filt_q;
    mic_d = mic_q;
    err_d = err_q;
    anc_d = anc_q;
    done_d = 1'b0;
    ovr_d = ovr_q | (start & run);
    if (!run && start) begin
      state_d = RUN;
      idx_d = '0;
      filt_d = FiltIn;
      mic_d = MicIn;
    end
    if (run) begin
      err_d[idx_q*W +: W] = d_sat;
      anc_d[idx_q*W +: W] = a_sat;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? IDLE : RUN;
      done_d = last;
    end
  end
  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      fc_q <= 1'b0;
      filt_q <= '0;
      mic_q <= '0;
      err_q <= '0;
      anc_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fc_q <= FiltComplete;
      filt_q <= filt_d;
      mic_q <= mic_d;
      err_q <= err_d;
      anc_q <= anc_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  end
`ifdef ANC_SAT_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sat;
  always_comb begin
    sat = (d_w[W] != d_w[W-1]) | (a_w[W] != a_w[W-1]);
    cnt_d = (run && sat && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign SatCount = cnt_q;
`else
  assign SatCount = '0;
`endif
  assign Err = err_q;
  assign ANCAudioOut = anc_q;
  assign Busy = run;
  assign Done = done_q;
  assign Overrun = ovr_q;
endmodule

// File: tb/tb_anc_sat_combiner.sv
// tb_anc_sat_combiner: directed scoreboard bench for anc_sat_combiner (W=11, CHANNELS=2, CNT_W=2).
module tb_anc_sat_combiner;
  localparam int W = 11;
  localparam int CH = 2;
  localparam int CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {logic [W*CH-1:0] err; logic [W*CH-1:0] anc;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W*CH-1:0] filt_in = '0, mic_in = '0, err, anc;
  logic fc = 1'b0;
  logic busy, done, overrun;
  logic [CNT_W-1:0] sat_count;
  exp_t sb[$];
  exp_t cur;
  logic [W*CH-1:0] m_err = '0, m_anc = '0;
  int sat_m = 0;
  int tests = 0, fails = 0;
  anc_sat_combiner #(.W(W), .CHANNELS(CH), .CNT_W(CNT_W)) dut (
    .Clk_100M(clk), .Rst_n(rst_n), .FiltIn(filt_in), .MicIn(mic_in),
    .FiltComplete(fc), .Err(err), .ANCAudioOut(anc), .Busy(busy),
    .Done(done), .Overrun(overrun), .SatCount(sat_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] clampv(input int v, output bit s);
    int hi = (1 << (W - 1)) - 1;
    int lo = -(1 << (W - 1));
    int r;
    s = (v > hi) || (v < lo);
    r = v > hi ? hi : (v < lo ? lo : v);
    return r[W-1:0];
  endfunction
  function automatic logic [CNT_W-1:0] exp_sat();
`ifdef ANC_SAT_COUNT_EN
    return sat_m[CNT_W-1:0];
`else
    return '0;
`endif
  endfunction
  task automatic set_frame(input int f0, input int f1, input int m0, input int m1);
    exp_t e;
    bit s0, s1, t0, t1;
    logic [W-1:0] e0, e1, a0, a1;
    filt_in = {W'(f1), W'(f0)};
    mic_in = {W'(m1), W'(m0)};
    e0 = clampv(m0 - f0, s0);
    e1 = clampv(m1 - f1, s1);
    a0 = clampv(-f0, t0);
    a1 = clampv(-f1, t1);
    e.err = {e1, e0};
    e.anc = {a1, a0};
    sb.push_back(e);
    if ((s0 | t0) && sat_m < CMAX) sat_m++;
    if ((s1 | t1) && sat_m < CMAX) sat_m++;
  endtask
  task automatic check_results(input string tag);
    cur = sb.pop_front();
    chk({tag, "_err"}, err, cur.err);
    chk({tag, "_anc"}, anc, cur.anc);
    chk({tag, "_satcnt"}, sat_count, exp_sat());
    m_err = cur.err;
    m_anc = cur.anc;
  endtask
  task automatic run_frame(input string tag);
    int n = 0;
    tick;
    chk({tag, "_busy_e0"}, busy, 1);
    while (!done && n < 8) begin
      tick;
      n++;
      if (n == 1) chk({tag, "_partial"}, err, {m_err[2*W-1:W], sb[0].err[W-1:0]});
    end
    chk({tag, "_latency"}, n, CH);
    chk({tag, "_busy_end"}, busy, 0);
    check_results(tag);
    tick;
    chk({tag, "_done_pulse"}, done, 0);
  endtask
  task automatic frame(input string tag, input int f0, input int f1, input int m0, input int m1);
    set_frame(f0, f1, m0, m1);
    fc = 1'b1;
    run_frame(tag);
    fc = 1'b0;
    tick;
  endtask
  initial begin
    int pulses;
    tick;
    tick;
    chk("rst_err", err, 0);
    chk("rst_anc", anc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_sat", sat_count, 0);
    rst_n = 1'b1;
    tick;
    set_frame(-48, -48, 9, 9);
    fc = 1'b1;
    run_frame("base");
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done || busy) pulses++;
    end
    chk("base_held_level", pulses, 0);
    fc = 1'b0;
    tick;
    frame("clamp", -1000, 1000, 1000, -1000);
    frame("negate", -1024, -1024, 0, 0);
    set_frame(100, -200, 7, 300);
    fc = 1'b1;
    tick;
    chk("ovr_busy_e0", busy, 1);
    chk("ovr_before", overrun, 0);
    fc = 1'b0;
    filt_in = {W'(-1024), W'(1000)};
    mic_in = {W'(-5), W'(-1000)};
    tick;
    fc = 1'b1;
    tick;
    chk("ovr_done", done, 1);
    chk("ovr_set", overrun, 1);
    check_results("ovr");
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (busy) pulses++;
    end
    chk("ovr_no_reframe", pulses, 0);
    chk("ovr_sticky", overrun, 1);
    fc = 1'b0;
    tick;
    set_frame(-1000, 1000, 1000, -1000);
    fc = 1'b1;
    tick;
    tick;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_anc", anc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_sat", sat_count, 0);
    sb.delete();
    m_err = '0;
    m_anc = '0;
    sat_m = 0;
    tick;
    rst_n = 1'b1;
    set_frame(-1000, 1000, 1000, -1000);
    run_frame("restart");
    fc = 1'b0;
    tick;
    frame("ceil1", -1024, 500, 0, -600);
    frame("ceil2", 3, -1024, 1023, 1);
    chk("ceil_final", sat_count, exp_sat());
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
